// File: rtl/pc_pkg.sv
// Shared constants and the next-PC select type for the program counter unit.
package pc_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned WORD_SHIFT  = 2;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_RET
  } pc_sel_e;

endpackage

// File: rtl/return_address_stack.sv
// Circular LIFO of return addresses; a push into a full stack overwrites the oldest entry.
module return_address_stack #(
  parameter  int unsigned XLEN      = 32,
  parameter  int unsigned RAS_DEPTH = 4,
  localparam int unsigned PW        = $clog2(RAS_DEPTH),
  localparam int unsigned CW        = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count,
  output logic            empty
);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   count_q;
  logic            pop_en;
  logic            push_en;

  // A pop of an empty stack is ignored; pop wins if both are requested.
  always_comb begin
    pop_en  = pop && (count_q != '0);
    push_en = push && !pop_en;
  end

  // Write pointer and occupancy; the pointer wraps so the oldest slot is reused when full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (pop_en) begin
      ptr_q   <= ptr_q - PW'(1);
      count_q <= count_q - CW'(1);
    end else if (push_en) begin
      ptr_q <= ptr_q + PW'(1);
      if (count_q != CW'(RAS_DEPTH)) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  // Entry storage, not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && push_en) begin
      mem_q[ptr_q] <= push_data;
    end
  end

  assign top   = mem_q[ptr_q - PW'(1)];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/pc_unit.sv
// Program counter with internal sequential/branch/jump/call/return target generation.
module pc_unit
  import pc_pkg::*;
#(
  parameter  int unsigned     XLEN      = 32,
  parameter  int unsigned     OFF_W     = 16,
  parameter  int unsigned     JIDX_W    = 26,
  parameter  int unsigned     RAS_DEPTH = 4,
  parameter  logic [XLEN-1:0] RESET_PC  = '0,
  localparam int unsigned     CW        = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic              equal,
  input  logic [OFF_W-1:0]  branch_offset,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   pc_plus4,
  output logic [CW-1:0]     ras_count,
  output logic              ras_underflow
);

  localparam logic [XLEN-1:0] JMASK = {XLEN{1'b1}} >> (XLEN - JIDX_W - WORD_SHIFT);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            uf_q;
  logic [XLEN-1:0] off_ext;
  logic [XLEN-1:0] btgt;
  logic [XLEN-1:0] jtgt;
  logic            taken;
  pc_sel_e         sel;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;

  assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);
  assign off_ext  = {{(XLEN-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};
  assign btgt     = pc_plus4 + (off_ext << WORD_SHIFT);
  // Upper bits come from pc+4; the word index replaces everything below them.
  assign jtgt     = (pc_plus4 & ~JMASK) | ({{(XLEN-JIDX_W){1'b0}}, jump_index} << WORD_SHIFT);
  assign taken    = branch & (equal ^ branch_ne);

  // Priority select: ret, call, jump, taken branch, sequential; stall suppresses stack updates.
  always_comb begin
    sel      = SEL_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (ret) begin
      ras_pop = 1'b1;
      if (!ras_empty) begin
        sel = SEL_RET;
      end
    end else if (call) begin
      ras_push = 1'b1;
      sel      = SEL_JMP;
    end else if (jump) begin
      sel = SEL_JMP;
    end else if (taken) begin
      sel = SEL_BR;
    end
    if (stall) begin
      ras_push = 1'b0;
      ras_pop  = 1'b0;
    end
    case (sel)
      SEL_BR:  pc_d = btgt;
      SEL_JMP: pc_d = jtgt;
      SEL_RET: pc_d = ras_top;
      default: pc_d = pc_plus4;
    endcase
  end

  // PC register and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      uf_q <= 1'b0;
    end else if (!stall) begin
      pc_q <= pc_d;
      if (ret && ras_empty) begin
        uf_q <= 1'b1;
      end
    end
  end

  return_address_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty)
  );

  assign pc_out        = pc_q;
  assign ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch, branch_ne, equal, jump, call, ret;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] pc_out, pc_plus4;
  logic [2:0]  ras_count;
  logic        ras_underflow;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_uf;

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN      (32),
    .OFF_W     (16),
    .JIDX_W    (26),
    .RAS_DEPTH (4),
    .RESET_PC  (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch        (branch),
    .branch_ne     (branch_ne),
    .equal         (equal),
    .branch_offset (branch_offset),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .jump_index    (jump_index),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .ras_count     (ras_count),
    .ras_underflow (ras_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b1; stall = 1'b0; branch = 1'b0; branch_ne = 1'b0; equal = 1'b0;
    jump = 1'b0; call = 1'b0; ret = 1'b0; branch_offset = '0; jump_index = '0;
  endtask

  // Advance the model by the spec rules, clock the DUT, compare everything.
  task automatic cycle();
    int          off;
    logic [31:0] jt;
    off = $signed(branch_offset);
    jt  = (((m_pc + 32'd4) >> 28) << 28) + jump_index * 4;
    if (!reset) begin
      m_pc = 32'h0; m_ras.delete(); m_uf = 1'b0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin m_pc = m_pc + 4; m_uf = 1'b1; end
    end else if (call) begin
      m_ras.push_back(m_pc + 4);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
      m_pc = jt;
    end else if (jump) begin
      m_pc = jt;
    end else if (branch && (equal != branch_ne)) begin
      m_pc = m_pc + 4 + off * 4;
    end else begin
      m_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
    check("pc_out", pc_out, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("ras_count", 32'(ras_count), m_ras.size());
    check("ras_underflow", 32'(ras_underflow), 32'(m_uf));
  endtask

  initial begin
    logic [31:0] pushed[5];
    logic [31:0] x;
    m_pc = '0; m_uf = 1'b0;

    // Reset and sequential run
    idle(); reset = 1'b0;
    cycle(); cycle();
    check("reset_pc", pc_out, 32'h0);
    reset = 1'b1;
    cycle(); check("seq1", pc_out, 32'h4);
    cycle(); check("seq2", pc_out, 32'h8);
    cycle(); check("seq3", pc_out, 32'hC);
    cycle(); check("seq4", pc_out, 32'h10);

    // BEQ taken backwards, then BNE not taken
    branch = 1'b1; equal = 1'b1; branch_offset = 16'hFFFE;
    cycle(); check("beq_taken", pc_out, 32'hC);
    idle(); cycle(); check("back_to_10", pc_out, 32'h10);
    branch = 1'b1; equal = 1'b1; branch_ne = 1'b1; branch_offset = 16'hFFFE;
    cycle(); check("bne_not_taken", pc_out, 32'h14);

    // Walk to 0x1000_0000 with maximal forward branches, then jump and stall
    idle(); reset = 1'b0; cycle(); reset = 1'b1;
    branch = 1'b1; equal = 1'b1; branch_offset = 16'h7FFF;
    repeat (2048) cycle();
    check("far_branch", pc_out, 32'h1000_0000);
    idle(); jump = 1'b1; jump_index = 26'h40;
    cycle(); check("jump", pc_out, 32'h1000_0100);
    idle(); stall = 1'b1; jump = 1'b1; ret = 1'b1;
    repeat (3) begin cycle(); check("stall_hold", pc_out, 32'h1000_0100); end

    // Call/return nesting
    idle(); reset = 1'b0; cycle(); reset = 1'b1;
    jump = 1'b1; jump_index = 26'h8; cycle(); check("to_20", pc_out, 32'h20);
    idle(); call = 1'b1; jump_index = 26'h100; cycle(); check("call1", pc_out, 32'h400);
    jump_index = 26'h200; cycle(); check("call2", pc_out, 32'h800);
    check("nest_count2", 32'(ras_count), 32'd2);
    idle(); ret = 1'b1;
    cycle(); check("ret1", pc_out, 32'h404);
    cycle(); check("ret2", pc_out, 32'h24);
    check("nest_count0", 32'(ras_count), 32'd0);

    // RAS overflow then underflow
    idle(); call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pushed[i] = m_pc + 32'd4;
      jump_index = 26'h1000 + 26'(i * 16);
      cycle();
    end
    check("ovf_count", 32'(ras_count), 32'd4);
    idle(); ret = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      cycle(); check("lifo_pop", pc_out, pushed[i]);
    end
    x = pc_out;
    cycle(); check("underflow_pc", pc_out, x + 32'd4);
    check("underflow_flag", 32'(ras_underflow), 32'd1);
    idle();
    repeat (3) begin cycle(); check("underflow_sticky", 32'(ras_underflow), 32'd1); end

    // call+ret together is a pop only
    call = 1'b1; jump_index = 26'h300; x = m_pc + 32'd4; cycle();
    call = 1'b1; ret = 1'b1; jump_index = 26'h500;
    cycle(); check("callret_pop", pc_out, x);
    check("callret_count", 32'(ras_count), 32'd0);

    // Reset beats stall and jump
    idle(); call = 1'b1; jump_index = 26'h77; cycle();
    idle(); reset = 1'b0; stall = 1'b1; jump = 1'b1; jump_index = 26'h123;
    cycle();
    check("reset_pri_pc", pc_out, 32'h0);
    check("reset_pri_cnt", 32'(ras_count), 32'd0);
    check("reset_pri_uf", 32'(ras_underflow), 32'd0);

    // Randomised mix against the model
    idle();
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 59) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      branch        = 1'($urandom);
      branch_ne     = 1'($urandom);
      equal         = 1'($urandom);
      jump          = ($urandom_range(0, 5) == 0);
      call          = ($urandom_range(0, 3) == 0);
      ret           = ($urandom_range(0, 3) == 0);
      branch_offset = 16'($urandom);
      jump_index    = 26'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
